// File: rtl/am_pkg.sv
// am_pkg: shared widths, FSM state type and default carrier threshold for the AM chain.
package am_pkg;
  localparam int SAMPLE_W = 16;
  localparam int OUT_W = 8;
  localparam logic [SAMPLE_W-1:0] AM_MIN_DIFF = 16'h0400;
  typedef enum logic [1:0] {IDLE, TRACK, DUMP} state_t;
endpackage

// File: rtl/am_win_minmax.sv
// am_win_minmax: per-window sample counter, running max/min and hold registers.
// o_close flags the accepted sample that ends a window; cnt==0 means the next valid sample starts one.
module am_win_minmax
  import am_pkg::*;
#(
  parameter int WIN_LEN = 64
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic                o_close,
  output logic [SAMPLE_W-1:0] o_hold_max,
  output logic [SAMPLE_W-1:0] o_hold_min
);
  localparam int CW = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);
  logic [CW-1:0] r_cnt;
  logic [SAMPLE_W-1:0] r_max, r_min, w_max, w_min;
  logic w_first;
  assign w_first = r_cnt == '0;
  assign w_max = (w_first || i_sample > r_max) ? i_sample : r_max;
  assign w_min = (w_first || i_sample < r_min) ? i_sample : r_min;
  assign o_close = i_valid && r_cnt == LAST;
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_max <= '0;
      r_min <= '0;
      o_hold_max <= '0;
      o_hold_min <= '0;
    end else if (i_valid) begin
      r_cnt <= o_close ? '0 : r_cnt + 1'b1;
      r_max <= w_max;
      r_min <= w_min;
      if (o_close) begin
        o_hold_max <= w_max;
        o_hold_min <= w_min;
      end
    end
  end
endmodule

// File: rtl/am_env_demod.sv
// am_env_demod: recovers the 8-bit AM envelope from the peak-to-peak span of each WIN_LEN window.
// Define AM_ENV_DEMOD_SMOOTH_EN to add a first-order IIR on the span (one extra cycle of latency).
module am_env_demod
  import am_pkg::*;
#(
  parameter int WIN_LEN = 64,
  parameter int SMOOTH_SHIFT = 2,
  parameter logic [SAMPLE_W-1:0] MIN_DIFF = AM_MIN_DIFF
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] modulate_in,
  input  logic                in_valid,
  output logic [OUT_W-1:0]    demod,
  output logic                demod_valid,
  output logic [SAMPLE_W-1:0] span,
  output logic                carrier_ok
);
  if (WIN_LEN < 2) begin : g_bad_win
    $error("WIN_LEN must be at least 2");
  end
  if (SMOOTH_SHIFT < 0 || SMOOTH_SHIFT > 16) begin : g_bad_shift
    $error("SMOOTH_SHIFT must be within 0..16");
  end
  state_t r_state;
  logic w_close, r_span_vld, r_dv;
  logic [SAMPLE_W-1:0] w_hold_max, w_hold_min, r_span_raw;
  am_win_minmax #(.WIN_LEN(WIN_LEN)) u_win (
    .clk_in(clk_in),
    .rst(rst),
    .i_valid(in_valid),
    .i_sample(modulate_in),
    .o_close(w_close),
    .o_hold_max(w_hold_max),
    .o_hold_min(w_hold_min)
  );
  // DUMP computes the span while the window tracker is already free to start the next window.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_span_raw <= '0;
      r_span_vld <= 1'b0;
      span <= '0;
      carrier_ok <= 1'b0;
    end else begin
      r_state <= (r_state == DUMP) ? TRACK : w_close ? DUMP : (r_state == IDLE && in_valid) ? TRACK : r_state;
      r_span_vld <= r_state == DUMP;
      if (r_state == DUMP) r_span_raw <= w_hold_max - w_hold_min;
      if (r_span_vld) begin
        span <= r_span_raw;
        carrier_ok <= r_span_raw >= MIN_DIFF;
      end
    end
  end
`ifdef AM_ENV_DEMOD_SMOOTH_EN
  logic r_upd, r_primed;
  logic [SAMPLE_W-1:0] r_y, w_y;
  logic signed [SAMPLE_W:0] w_diff, w_step;
  logic signed [SAMPLE_W+1:0] w_sum;
  assign w_diff = $signed({1'b0, span}) - $signed({1'b0, r_y});
  assign w_step = w_diff >>> SMOOTH_SHIFT;
  assign w_sum = $signed({2'b00, r_y}) + $signed({w_step[SAMPLE_W], w_step});
  assign w_y = w_sum[SAMPLE_W+1] ? '0 : w_sum[SAMPLE_W] ? '1 : w_sum[SAMPLE_W-1:0];
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_upd <= 1'b0;
      r_primed <= 1'b0;
      r_y <= '0;
      r_dv <= 1'b0;
    end else begin
      r_upd <= r_span_vld;
      r_dv <= r_upd;
      if (r_upd) begin
        r_y <= r_primed ? w_y : span;
        r_primed <= 1'b1;
      end
    end
  end
  assign demod = r_y[SAMPLE_W-1 -: OUT_W];
`else
  logic [OUT_W-1:0] r_demod;
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_demod <= '0;
      r_dv <= 1'b0;
    end else begin
      r_dv <= r_span_vld;
      if (r_span_vld) r_demod <= r_span_raw[SAMPLE_W-1 -: OUT_W];
    end
  end
  assign demod = r_demod;
`endif
  assign demod_valid = r_dv;
endmodule

// File: tb/tb_am_env_demod.sv
// tb_am_env_demod: directed self-checking bench for am_env_demod.
// Follows AM_ENV_DEMOD_SMOOTH_EN to pick the raw or smoothed test sequence.
module tb_am_env_demod;
  import am_pkg::*;
`ifdef AM_ENV_DEMOD_SMOOTH_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk_in = 1'b0;
  logic rst = 1'b0;
  logic [15:0] modulate_in = '0;
  logic in_valid = 1'b0;
  logic [7:0] demod;
  logic demod_valid;
  logic [15:0] span;
  logic carrier_ok;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] q_dm[$];
  int q_cy[$];
  am_env_demod dut (
    .clk_in(clk_in),
    .rst(rst),
    .modulate_in(modulate_in),
    .in_valid(in_valid),
    .demod(demod),
    .demod_valid(demod_valid),
    .span(span),
    .carrier_ok(carrier_ok)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  always @(negedge clk_in) begin
    if (demod_valid === 1'b1) begin
      q_dm.push_back(demod);
      q_cy.push_back(cyc);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [15:0] s, input logic v);
    @(negedge clk_in);
    modulate_in = s;
    in_valid = v;
  endtask
  // sample 0 is always a; later samples alternate a/b when alt is set, otherwise all b
  task automatic burst(input int n, input logic [15:0] a, input logic [15:0] b, input bit alt);
    for (int i = 0; i < n; i++) send((i == 0 || (alt && i % 2 == 0)) ? a : b, 1'b1);
  endtask
  task automatic finish_window(input string tag, input logic [15:0] esp, input logic [7:0] edm, input logic ecar);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk_in);
      in_valid = 1'b0;
      chk({tag, "_dv"}, demod_valid, k == LAT + 1);
    end
    chk({tag, "_span"}, span, esp);
    chk({tag, "_demod"}, demod, edm);
    chk({tag, "_carrier"}, carrier_ok, ecar);
    @(negedge clk_in);
    chk({tag, "_dv_off"}, demod_valid, 1'b0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_demod"}, demod, 8'h00);
    chk({tag, "_dv"}, demod_valid, 1'b0);
    chk({tag, "_span"}, span, 16'h0000);
    chk({tag, "_carrier"}, carrier_ok, 1'b0);
  endtask
  initial begin
    repeat (2) @(negedge clk_in);
    chk_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk_in);
`ifdef AM_ENV_DEMOD_SMOOTH_EN
    burst(64, 16'h5000, 16'h5000, 1'b1);
    finish_window("smooth0", 16'h0000, 8'h00, 1'b0);
    burst(64, 16'h0000, 16'h8000, 1'b1);
    finish_window("smooth1", 16'h8000, 8'h20, 1'b1);
    burst(64, 16'h0000, 16'h8000, 1'b1);
    finish_window("smooth2", 16'h8000, 8'h38, 1'b1);
`else
    q_dm.delete();
    burst(64, 16'h0000, 16'hFE01, 1'b1);
    finish_window("alt", 16'hFE01, 8'hFE, 1'b1);
    chk("alt_pulses", q_dm.size(), 1);
    burst(64, 16'h4000, 16'h4000, 1'b1);
    finish_window("const", 16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 128; i++)
      send(i[0] ? (((i >> 1) % 2 == 0) ? 16'h0000 : 16'hFE01) : 16'hFFFF, i[0]);
    finish_window("gap", 16'hFE01, 8'hFE, 1'b1);
    q_dm.delete();
    q_cy.delete();
    burst(64, 16'h1000, 16'h2000, 1'b0);
    burst(64, 16'h0000, 16'h3000, 1'b0);
    finish_window("b2b", 16'h3000, 8'h30, 1'b1);
    chk("b2b_pulses", q_dm.size(), 2);
    if (q_dm.size() == 2) begin
      chk("b2b_first", q_dm[0], 8'h10);
      chk("b2b_second", q_dm[1], 8'h30);
      chk("b2b_spacing", q_cy[1] - q_cy[0], 64);
    end
    burst(64, 16'h1000, 16'h1400, 1'b1);
    finish_window("thr_eq", 16'h0400, 8'h04, 1'b1);
    burst(64, 16'h1000, 16'h13FF, 1'b1);
    finish_window("thr_below", 16'h03FF, 8'h03, 1'b0);
    burst(64, 16'h0000, 16'hFE01, 1'b1);
    finish_window("pre_rst", 16'hFE01, 8'hFE, 1'b1);
    burst(40, 16'h0000, 16'hFE01, 1'b1);
    @(negedge clk_in);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk_in);
    chk_zero("midrst_hold");
    rst = 1'b1;
    q_dm.delete();
    burst(64, 16'h0000, 16'h0800, 1'b1);
    finish_window("post_rst", 16'h0800, 8'h08, 1'b1);
    repeat (70) @(negedge clk_in);
    chk("post_rst_pulses", q_dm.size(), 1);
    if (q_dm.size() == 1) chk("post_rst_demod", q_dm[0], 8'h08);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/am_env_demod.md
# am_env_demod

Envelope demodulator for the AM chain: consumes the unsigned 16-bit modulated stream produced by the modulator stage, which is the offset-binary envelope times the carrier, and recovers the 8-bit offset-binary envelope. Each window of WIN_LEN samples is tracked for max/min. The peak-to-peak span gives the envelope, decimated by WIN_LEN. A carrier-present flag goes to the status/LED logic, and the 8-bit output feeds the baseband DAC/compare path.

## Interface
- WIN_LEN, 64: samples per window; must be ≥2 and span ≥1 carrier period.
- SMOOTH_SHIFT, 2: IIR coefficient 2^-SMOOTH_SHIFT (used only with smoothing compiled in).
- MIN_DIFF, 16'h0400: minimum window span that counts as carrier present.
- clk_in  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- modulate_in  in  16  unsigned modulated sample.
- in_valid  in  1  sample qualifier; modulate_in is ignored when low.
- demod  out  8  recovered envelope, offset-binary (≈ modulator envelope byte).
- demod_valid  out  1  one-cycle strobe per window when demod updates.
- span  out  16  last raw window span (max−min).
- carrier_ok  out  1  span of last completed window ≥ MIN_DIFF.

## Operation
- FSM states:
  - IDLE: after reset; waits for first in_valid.
  - TRACK: collecting a window.
  - DUMP: single cycle, entered after a window's last sample.
- IDLE→TRACK: first valid sample loads win_max=win_min=sample, cnt=1.
- TRACK: per valid sample, win_max=max(win_max,s) and win_min=min(win_min,s); cnt++.
  - Sample with cnt==WIN_LEN−1 closes the window: final max/min, including that sample, are latched into hold registers; cnt→0; state→DUMP.
- DUMP: span_r=hold_max−hold_min (unsigned, never negative, 16 bits). A valid sample arriving in DUMP opens the next window (loads max/min, cnt=1); state→TRACK, so no sample is ever dropped. Without a valid sample, state→TRACK with cnt=0; the next valid sample loads max/min.
- carrier_ok updates with span.
- in_valid low anywhere: counters and extrema hold.
- demod=y[15:8], where y is the output register (raw span or smoothed value).

## Timing
- Window closes on cycle T (accepted sample with cnt==WIN_LEN−1).
  - T+1: DUMP cycle computing span_r.
  - T+2: span, carrier_ok, and y (raw) registered. demod_valid high for one cycle at T+2 without smoothing, T+3 with smoothing.
- Throughput: one sample/cycle sustained; gaps allowed arbitrarily.
- Reset values: demod=0, demod_valid=0, span=0, carrier_ok=0, y=0, cnt=0, state=IDLE.
- Reset mid-window discards the partial window; no demod_valid until a full WIN_LEN-sample window completes after release.
- Constant input: span=0, demod=0, carrier_ok=0.

## Configuration
- AM_ENV_DEMOD_SMOOTH_EN defined: first-order IIR y ← y + ((span−y)>>>SMOOTH_SHIFT).
  - Uses 17-bit signed difference; arithmetic shift; result clamped to 0..65535.
  - First window after reset primes y=span directly.
  - Adds one cycle of latency.
- Undefined: y=span, no IIR registers.

## Structure
- Package am_pkg holds:
  - SAMPLE_W=16 and OUT_W=8.
  - FSM state enum (IDLE, TRACK, DUMP).
  - Default MIN_DIFF constant, shared with the modulator testbench.
- One sub-module: am_win_minmax (window counter, running max/min, hold registers, close strobe). The top holds the FSM glue, span, IIR and flags.

## Test plan
- Alternating 16'h0000/16'hFE01 for 64 valid cycles, no smoothing → at T+2 span=16'hFE01, demod=8'hFE, carrier_ok=1, one demod_valid pulse.
- 64 samples of constant 16'h4000 → span=0, demod=0, carrier_ok=0.
- Same alternating pattern with in_valid toggling every other cycle → identical result after 128 cycles; extrema unaffected by invalid-cycle data 16'hFFFF.
- Back-to-back windows, valid every cycle, spans 16'h1000 then 16'h3000 → two strobes exactly WIN_LEN cycles apart, demod 8'h10 then 8'h30, no sample lost.
- Assert rst at sample 40 of a window, release, send 64 samples → exactly one demod_valid, from the post-reset window only; all outputs 0 during reset.
- AM_ENV_DEMOD_SMOOTH_EN, SMOOTH_SHIFT=2, window spans 16'h0000, 16'h8000, 16'h8000 → demod 8'h00 (primed), 8'h20, 8'h38, each at T+3.
